// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_pkg
//  Purpose  : Shared state encoding, light codes and counter helpers for the
//             two-street traffic scheduler with pedestrian walk phase.
//  Revision : 1.0  initial release
// ============================================================================
package traffic_pkg;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // 3-bit state codes; these are also what the debug phase output shows
  typedef enum logic [2:0] {
    A_GREEN   = 3'd0,
    A_YELLOW  = 3'd1,
    ALLRED_AB = 3'd2,
    B_GREEN   = 3'd3,
    B_YELLOW  = 3'd4,
    ALLRED_BA = 3'd5,
    WALK      = 3'd6
  } state_e;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  // Ticks elapsed in the current phase, one bit wider so a saturated count
  // still compares as 256.
  function automatic logic [CNT_W:0] elapsed_of(input logic [CNT_W-1:0] cnt);
    return {1'b0, cnt} + (CNT_W+1)'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : phase_timer
//  Purpose  : 8-bit saturating tick counter; cleared whenever the scheduler
//             changes state.
//  Revision : 1.0  initial release
// ============================================================================
module phase_timer
  import traffic_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  // Clear has priority over counting so a new phase always starts at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/traffic_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_scheduler
//  Purpose  : Two-street traffic light controller with demand-driven greens,
//             fixed yellow / all-red clearance and a pedestrian walk phase
//             inserted after either all-red.
//  Revision : 1.0  initial release
// ============================================================================
module traffic_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 10,
  parameter int unsigned YELLOW_T  = 2,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       TA,
  input  logic       TB,
  input  logic       ped_req,
  output logic [1:0] LA,
  output logic [1:0] LB,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [CNT_W:0] G_MIN = (CNT_W+1)'(GREEN_MIN);
  localparam logic [CNT_W:0] G_MAX = (CNT_W+1)'(GREEN_MAX);
  localparam logic [CNT_W:0] Y_T   = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0] AR_T  = (CNT_W+1)'(ALLRED_T);
  localparam logic [CNT_W:0] W_T   = (CNT_W+1)'(WALK_T);

  state_e           state_q, state_d;
  logic             ped_pending_q, ped_pending_d;
  logic             next_b_q, next_b_d;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W:0]   w_elapsed;
  logic             w_clear;
  logic             w_demand_a, w_demand_b;

  phase_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (w_clear),
    .tick  (tick),
    .cnt   (w_cnt)
  );

  assign w_elapsed  = elapsed_of(w_cnt);
  assign w_demand_a = TA | ped_pending_q;
  assign w_demand_b = TB | ped_pending_q;
  // Any state change restarts the phase timer
  assign w_clear    = (state_d != state_q);

  // State, pending pedestrian request and walk-exit direction registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= A_GREEN;
      ped_pending_q <= 1'b0;
      next_b_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
      next_b_q      <= next_b_d;
    end
  end

  // Next-state logic; transitions are evaluated only on tick cycles
  always_comb begin
    state_d  = state_q;
    next_b_d = next_b_q;
    // Requests made during the walk itself are served by it, so drop them
    ped_pending_d = (state_q == WALK) ? 1'b0 : (ped_pending_q | ped_req);

    if (tick) begin
      case (state_q)
        A_GREEN: begin
          if (w_demand_b && ((w_elapsed >= G_MAX) || ((w_elapsed >= G_MIN) && !TA)))
            state_d = A_YELLOW;
        end
        A_YELLOW: begin
          if (w_elapsed == Y_T) state_d = ALLRED_AB;
        end
        ALLRED_AB: begin
          if (w_elapsed == AR_T) state_d = ped_pending_q ? WALK : B_GREEN;
        end
        B_GREEN: begin
          if (w_demand_a && ((w_elapsed >= G_MAX) || ((w_elapsed >= G_MIN) && !TB)))
            state_d = B_YELLOW;
        end
        B_YELLOW: begin
          if (w_elapsed == Y_T) state_d = ALLRED_BA;
        end
        ALLRED_BA: begin
          if (w_elapsed == AR_T) state_d = ped_pending_q ? WALK : A_GREEN;
        end
        WALK: begin
          if (w_elapsed == W_T) state_d = next_b_q ? B_GREEN : A_GREEN;
        end
        default: state_d = A_GREEN;
      endcase
    end

    // Remember which street was about to get green when the walk began
    if ((state_d == WALK) && (state_q != WALK))
      next_b_d = (state_q == ALLRED_AB);
  end

  // Moore light decode from the state register
  always_comb begin
    LA   = RED;
    LB   = RED;
    walk = 1'b0;
    case (state_q)
      A_GREEN:  LA = GREEN;
      A_YELLOW: LA = YELLOW;
      B_GREEN:  LB = GREEN;
      B_YELLOW: LB = YELLOW;
      WALK:     walk = 1'b1;
      default: begin
        LA = RED;
        LB = RED;
      end
    endcase
  end

  assign phase = state_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_scheduler
//  Purpose  : Directed self-checking bench for traffic_scheduler (default
//             parameters).
//  Revision : 1.0  initial release
// ============================================================================
module tb_traffic_scheduler;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       reset, tick, TA, TB, ped_req;
  logic [1:0] LA, LB;
  logic       walk;
  logic [2:0] phase;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_scheduler dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .TA      (TA),
    .TB      (TB),
    .ped_req (ped_req),
    .LA      (LA),
    .LB      (LB),
    .walk    (walk),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Expected phase per tick for TA=TB=1
  function automatic logic [2:0] exp_both(input int k);
    if (k <= 10) return A_GREEN;
    if (k <= 12) return A_YELLOW;
    if (k == 13) return ALLRED_AB;
    if (k <= 23) return B_GREEN;
    if (k <= 25) return B_YELLOW;
    if (k == 26) return ALLRED_BA;
    return A_GREEN;
  endfunction

  // Expected phase per tick for the pedestrian sequence (TA=TB=0)
  function automatic logic [2:0] exp_ped(input int k);
    if (k <= 4)  return A_GREEN;
    if (k <= 6)  return A_YELLOW;
    if (k == 7)  return ALLRED_AB;
    if (k <= 10) return WALK;
    if (k <= 14) return B_GREEN;
    if (k <= 16) return B_YELLOW;
    if (k == 17) return ALLRED_BA;
    if (k <= 20) return WALK;
    return A_GREEN;
  endfunction

  initial begin
    logic [3:0] exp_l;
    reset = 1'b1; tick = 1'b1; TA = 1'b1; TB = 1'b0; ped_req = 1'b0;

    // Reset state, then A holds green with no B demand; counter saturates
    apply_reset();
    check("rst_phase", 32'(phase), 32'(A_GREEN));
    check("rst_LA", 32'(LA), 32'(2'b00));
    check("rst_LB", 32'(LB), 32'(2'b10));
    check("rst_walk", 32'(walk), 32'(1'b0));
    check("rst_cnt", 32'(dut.w_cnt), 32'd0);
    for (int i = 0; i < 300; i++) begin
      step();
      check("a_hold_lights", 32'({LA, LB}), 32'(4'b0010));
    end
    check("cnt_sat", 32'(dut.w_cnt), 32'd255);
    TB = 1'b1;
    step();
    check("sat_to_yellow", 32'(phase), 32'(A_YELLOW));

    // TA=0, TB=1: minimum green then hand over to B
    TA = 1'b0; TB = 1'b1;
    apply_reset();
    for (int k = 1; k <= 12; k++) begin
      if (k <= 4)      exp_l = 4'b0010;
      else if (k <= 6) exp_l = 4'b0110;
      else if (k == 7) exp_l = 4'b1010;
      else             exp_l = 4'b1000;
      check($sformatf("min_green_t%0d", k), 32'({LA, LB}), 32'(exp_l));
      step();
    end

    // TA=TB=1: both greens end at GREEN_MAX
    TA = 1'b1; TB = 1'b1;
    apply_reset();
    for (int k = 1; k <= 28; k++) begin
      check($sformatf("max_green_t%0d", k), 32'(phase), 32'(exp_both(k)));
      step();
    end

    // Pedestrian walk from both all-red directions; request during walk dropped
    TA = 1'b0; TB = 1'b0;
    apply_reset();
    for (int k = 1; k <= 22; k++) begin
      check($sformatf("ped_phase_t%0d", k), 32'(phase), 32'(exp_ped(k)));
      if ((k >= 8 && k <= 10) || (k >= 18 && k <= 20)) begin
        check($sformatf("ped_walk_t%0d", k), 32'(walk), 32'(1'b1));
        check($sformatf("ped_red_t%0d", k), 32'({LA, LB}), 32'(4'b1010));
      end else begin
        check($sformatf("ped_nowalk_t%0d", k), 32'(walk), 32'(1'b0));
      end
      if (k == 11) check("ped_cleared", 32'(dut.ped_pending_q), 32'(1'b0));
      ped_req = (k == 1) || (k == 9) || (k == 12);
      step();
      ped_req = 1'b0;
    end

    // Reset in A_YELLOW with a pending request aborts immediately
    TA = 1'b0; TB = 1'b1;
    apply_reset();
    for (int k = 1; k <= 4; k++) begin
      ped_req = (k == 2);
      step();
      ped_req = 1'b0;
    end
    check("abort_pre_phase", 32'(phase), 32'(A_YELLOW));
    check("abort_pre_pend", 32'(dut.ped_pending_q), 32'(1'b1));
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_lights", 32'({LA, LB}), 32'(4'b0010));
    check("abort_pend", 32'(dut.ped_pending_q), 32'(1'b0));
    check("abort_cnt", 32'(dut.w_cnt), 32'd0);

    // tick=0 freezes state, counter and outputs
    apply_reset();
    for (int k = 1; k <= 5; k++) step();
    check("freeze_pre_phase", 32'(phase), 32'(A_YELLOW));
    check("freeze_pre_cnt", 32'(dut.w_cnt), 32'd1);
    tick = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("freeze_phase", 32'(phase), 32'(A_YELLOW));
      check("freeze_cnt", 32'(dut.w_cnt), 32'd1);
      check("freeze_lights", 32'({LA, LB}), 32'(4'b0110));
    end
    tick = 1'b1;
    step();
    check("resume_allred", 32'(phase), 32'(ALLRED_AB));
    step();
    check("resume_bgreen", 32'(phase), 32'(B_GREEN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
